// File: rtl/common_apb3_regbank_if.sv
// APB3 request/response bundle for the common register bank.
// The master drives the request; the slave returns data, ready and error.
interface common_apb3_regbank_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERROR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERROR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERROR
  );
endinterface

// File: rtl/common_apb3_regbank.sv
// APB3 register bank: RW control, RO status, W1C interrupts,
// self-clearing pulse strobes and a constant ID word.
module common_apb3_regbank #(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_CTRL    = 8,
  parameter int          NUM_STAT    = 10,
  parameter int          NUM_IRQ     = 8,
  parameter int          NUM_PULSE   = 4,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hABCD_5678
) (
  input  logic                           clk,
  input  logic                           resetn,
  common_apb3_regbank_if.slave           apb,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_out,
  input  logic [NUM_STAT*DATA_WIDTH-1:0] status_in,
  input  logic [NUM_IRQ-1:0]             irq_src,
  output logic                           irq,
  output logic [NUM_PULSE-1:0]           pulse_out
);

  localparam int DW = DATA_WIDTH;
  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [WW-1:0] W_IRQS  = WW'(48);
  localparam logic [WW-1:0] W_IRQE  = WW'(49);
  localparam logic [WW-1:0] W_PULSE = WW'(50);
  localparam logic [WW-1:0] W_ID    = WW'(51);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [DW-1:0]        ctrl_q [NUM_CTRL];
  logic [DW-1:0]        ctrl_d [NUM_CTRL];
  logic [NUM_IRQ-1:0]   irq_st_q, irq_st_d;
  logic [NUM_IRQ-1:0]   irq_en_q, irq_en_d;
  logic [NUM_IRQ-1:0]   src_q;
  logic [NUM_IRQ-1:0]   clr;
  logic [DW-1:0]        prdata_q, prdata_d;
  logic [NUM_PULSE-1:0] pulse_q, pulse_d;
  logic                 irq_q, irq_d;

  logic [WW-1:0] w;
  logic          hit_ctrl, hit_stat, hit_irqs;
  logic          hit_irqe, hit_pulse, hit_id;
  logic          err, pready, commit, cap;
  logic [DW-1:0] map_rd, rdata;

  assign w         = apb.PADDR[ADDR_WIDTH-1:2];
  assign hit_ctrl  = w < WW'(NUM_CTRL);
  assign hit_stat  = (w >= WW'(32)) && (w < WW'(32 + NUM_STAT));
  assign hit_irqs  = w == W_IRQS;
  assign hit_irqe  = w == W_IRQE;
  assign hit_pulse = w == W_PULSE;
  assign hit_id    = w == W_ID;

  assign err = (apb.PADDR[1:0] != 2'b00)
    | !(hit_ctrl | hit_stat | hit_irqs | hit_irqe | hit_pulse | hit_id)
    | (apb.PWRITE & (hit_stat | hit_id));

  assign pready = (state_q == ACCESS) && (cnt_q == 4'(WAIT_CYCLES));
  assign commit = pready & apb.PSEL & apb.PWRITE & !err;
  assign cap    = (state_q == SETUP) & apb.PSEL
                & apb.PENABLE & !apb.PWRITE;

  // Array words are matched by loop; non-matching slots contribute zero.
  always_comb begin
    map_rd = '0;
    for (int i = 0; i < NUM_CTRL; i++)
      if (w == WW'(i)) map_rd = ctrl_q[i];
    for (int i = 0; i < NUM_STAT; i++)
      if (w == WW'(32 + i)) map_rd = status_in[i*DW +: DW];
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_irqs: rdata = DW'(irq_st_q);
      hit_irqe: rdata = DW'(irq_en_q);
      hit_id:   rdata = DW'(ID_VALUE);
      default:  rdata = map_rd;
    endcase
    if (err) rdata = '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (apb.PSEL && !apb.PENABLE) state_d = SETUP;
      end
      SETUP: begin
        if (apb.PSEL && apb.PENABLE) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!pready) cnt_d = cnt_q + 4'd1;
        if (!apb.PSEL || pready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A set from a fresh source edge overrides a same-cycle W1C clear.
  always_comb begin
    ctrl_d = ctrl_q;
    for (int i = 0; i < NUM_CTRL; i++)
      if (commit && hit_ctrl && w == WW'(i)) ctrl_d[i] = apb.PWDATA;
    clr      = (commit && hit_irqs) ? apb.PWDATA[NUM_IRQ-1:0] : '0;
    irq_st_d = (irq_st_q & ~clr) | (irq_src & ~src_q);
    irq_en_d = (commit && hit_irqe) ? apb.PWDATA[NUM_IRQ-1:0]
                                    : irq_en_q;
    pulse_d  = (commit && hit_pulse) ? apb.PWDATA[NUM_PULSE-1:0]
                                     : '0;
    irq_d    = |(irq_st_q & irq_en_q);
    prdata_d = cap ? rdata : prdata_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= '0;
      irq_st_q <= '0;
      irq_en_q <= '0;
      src_q    <= '0;
      prdata_q <= '0;
      pulse_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
      irq_st_q <= irq_st_d;
      irq_en_q <= irq_en_d;
      src_q    <= irq_src;
      prdata_q <= prdata_d;
      pulse_q  <= pulse_d;
      irq_q    <= irq_d;
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
    assign ctrl_out[g*DW +: DW] = ctrl_q[g];
  end

  assign apb.PRDATA    = prdata_q;
  assign apb.PREADY    = pready;
  assign apb.PSLVERROR = pready & err;
  assign irq           = irq_q;
  assign pulse_out     = pulse_q;

endmodule
